cmd_arb: RTL and testbench

//  Two-requester round-robin arbiter sharing one command executor (e.g. tap_exe) between two cmd/rsp FIFO pairs.

---
 rtl/cmd_arb_pkg.sv | 24 ++
 rtl/cmd_arb_if.sv | 31 +++
 rtl/cmd_arb_exe_timer.sv | 31 +++
 rtl/cmd_arb.sv | 141 ++++++++++++++
 tb/tb_cmd_arb.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmd_arb_pkg.sv
// Shared types for the two-requester command arbiter: FSM states, word type,
// default timeout response and the round-robin pick rule.
package cmd_arb_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t TIMEOUT_RSP_DEF = 32'hDEAD_0000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RD_CMD = 2'd1,
    S_EXE    = 2'd2,
    S_WR_RSP = 2'd3
  } state_t;

  // Lone requester wins outright; on a tie the one not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return !last;
    return req1;
  endfunction

endpackage

// File: rtl/cmd_arb_if.sv
// Cmd/rsp FIFO pairs for both requesters plus the executor handshake.
// master = arbiter side, slave = FIFOs/executor side.
interface cmd_arb_if;
  import cmd_arb_pkg::*;

  word_t cmd_data0, cmd_data1;
  logic  cmd_waitreq0, cmd_waitreq1;
  logic  cmd_rdreq0, cmd_rdreq1;
  word_t rsp_data0, rsp_data1;
  logic  rsp_waitreq0, rsp_waitreq1;
  logic  rsp_wrreq0, rsp_wrreq1;
  logic  exe_run;
  word_t exe_cmd;
  word_t exe_rsp;
  logic  exe_done;

  modport master (
    input  cmd_data0, cmd_data1, cmd_waitreq0, cmd_waitreq1,
    input  rsp_waitreq0, rsp_waitreq1, exe_rsp, exe_done,
    output cmd_rdreq0, cmd_rdreq1, rsp_data0, rsp_data1,
    output rsp_wrreq0, rsp_wrreq1, exe_run, exe_cmd
  );

  modport slave (
    output cmd_data0, cmd_data1, cmd_waitreq0, cmd_waitreq1,
    output rsp_waitreq0, rsp_waitreq1, exe_rsp, exe_done,
    input  cmd_rdreq0, cmd_rdreq1, rsp_data0, rsp_data1,
    input  rsp_wrreq0, rsp_wrreq1, exe_run, exe_cmd
  );

endinterface

// File: rtl/cmd_arb_exe_timer.sv
// Cycle timer for the executor stay: cleared before a run, counts while enabled,
// flags expire on its last permitted cycle (TIMEOUT_CYC-1) and holds there.
module cmd_arb_exe_timer #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expire) cnt_d = cnt_q + TW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire = (cnt_q == LAST);

endmodule

// File: rtl/cmd_arb.sv
// Round-robin arbiter sharing one command executor between two cmd/rsp FIFO pairs;
// one command in flight, responses to a full rsp FIFO are dropped and counted.
module cmd_arb
  import cmd_arb_pkg::*;
#(
  parameter int    TIMEOUT_CYC = 1024,
  parameter int    CNT_W       = 8,
  parameter word_t TIMEOUT_RSP = TIMEOUT_RSP_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  cmd_arb_if.master        bus,
  output logic             gnt_id,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] tmo_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             last_q, last_d;
  word_t            cmd_q, cmd_d;
  word_t            rsp_q, rsp_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;

  logic  req0, req1, rsp_full;
  logic  tmr_clr, tmr_en, tmr_expire;
  logic  rdreq0, rdreq1, wrreq0, wrreq1, run;
  word_t rsp_dat0, rsp_dat1;

  assign req0     = !bus.cmd_waitreq0;
  assign req1     = !bus.cmd_waitreq1;
  assign rsp_full = gnt_q ? bus.rsp_waitreq1 : bus.rsp_waitreq0;

  cmd_arb_exe_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expire (tmr_expire)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    rsp_d    = rsp_q;
    drop_d   = drop_q;
    tmo_d    = tmo_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    rdreq0   = 1'b0;
    rdreq1   = 1'b0;
    wrreq0   = 1'b0;
    wrreq1   = 1'b0;
    run      = 1'b0;
    rsp_dat0 = '0;
    rsp_dat1 = '0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = rr_pick(req0, req1, last_q);
          state_d = S_RD_CMD;
        end
      end
      S_RD_CMD: begin
        rdreq0  = !gnt_q;
        rdreq1  = gnt_q;
        cmd_d   = gnt_q ? bus.cmd_data1 : bus.cmd_data0;
        tmr_clr = 1'b1;
        state_d = S_EXE;
      end
      S_EXE: begin
        run    = 1'b1;
        tmr_en = 1'b1;
        // A done on the expiry cycle still delivers the real response.
        if (bus.exe_done) begin
          rsp_d   = bus.exe_rsp;
          state_d = S_WR_RSP;
        end else if (tmr_expire) begin
          rsp_d   = TIMEOUT_RSP;
          if (tmo_q != CNT_MAX) tmo_d = tmo_q + CNT_W'(1);
          state_d = S_WR_RSP;
        end
      end
      S_WR_RSP: begin
        rsp_dat0 = gnt_q ? '0 : rsp_q;
        rsp_dat1 = gnt_q ? rsp_q : '0;
        // Never stall on a full rsp FIFO: drop the word so the executor stays free.
        if (!rsp_full) begin
          wrreq0 = !gnt_q;
          wrreq1 = gnt_q;
        end else if (drop_q != CNT_MAX) begin
          drop_d = drop_q + CNT_W'(1);
        end
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cmd_q   <= '0;
      rsp_q   <= '0;
      drop_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
      drop_q  <= drop_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.cmd_rdreq0 = rdreq0;
  assign bus.cmd_rdreq1 = rdreq1;
  assign bus.rsp_wrreq0 = wrreq0;
  assign bus.rsp_wrreq1 = wrreq1;
  assign bus.rsp_data0  = rsp_dat0;
  assign bus.rsp_data1  = rsp_dat1;
  assign bus.exe_run    = run;
  assign bus.exe_cmd    = cmd_q;

  assign gnt_id   = gnt_q;
  assign busy     = (state_q != S_IDLE);
  assign drop_cnt = drop_q;
  assign tmo_cnt  = tmo_q;

endmodule

// File: tb/tb_cmd_arb.sv
// Directed and randomized scenarios for cmd_arb, each checked against a
// transaction-level model of grant order, run length, responses and counters.
module tb_cmd_arb;
  import cmd_arb_pkg::*;

  localparam int TCYC = 16;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          gnt_id, busy;
  logic [CW-1:0] drop_cnt, tmo_cnt;

  cmd_arb_if bus();

  cmd_arb #(.TIMEOUT_CYC(TCYC), .CNT_W(CW), .TIMEOUT_RSP(32'hDEAD_0000)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .gnt_id   (gnt_id),
    .busy     (busy),
    .drop_cnt (drop_cnt),
    .tmo_cnt  (tmo_cnt)
  );

  always #5 clk = ~clk;

  int    n_chk = 0, n_fail = 0;
  word_t cq0[$], cq1[$];
  int    dly_tbl[$];
  bit    full_tbl[$];
  int    tx_idx, cyc, run_idx, viol;
  bit    s_rd0, s_rd1, idle_pulse;
  int    g_log[$], g_cyc[$], run_log[$], p_port[$];
  word_t ecmd_log[$], p_dat[$];
  int    m_last, m_drop, m_tmo;

  function automatic word_t exe_fn(input word_t c);
    return {c[15:0], c[31:16]} ^ 32'h0F0F_A5A5;
  endfunction

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_tx(input int d, input bit f);
    dly_tbl.push_back(d);
    full_tbl.push_back(f);
  endtask

  task automatic clear_logs();
    g_log.delete(); g_cyc.delete(); run_log.delete(); p_port.delete();
    ecmd_log.delete(); p_dat.delete(); dly_tbl.delete(); full_tbl.delete();
    tx_idx = -1;
    viol   = 0;
  endtask

  // Executor answers on run cycle d of the current transaction (d<0: never).
  task automatic drive();
    int d;
    bit f;
    d = 2;
    f = 1'b0;
    if (tx_idx >= 0 && tx_idx < dly_tbl.size()) d = dly_tbl[tx_idx];
    if (tx_idx >= 0 && tx_idx < full_tbl.size()) f = full_tbl[tx_idx];
    bus.cmd_waitreq0 = (cq0.size() == 0);
    bus.cmd_waitreq1 = (cq1.size() == 0);
    bus.cmd_data0    = (cq0.size() != 0) ? cq0[0] : 32'h0;
    bus.cmd_data1    = (cq1.size() != 0) ? cq1[0] : 32'h0;
    bus.rsp_waitreq0 = f;
    bus.rsp_waitreq1 = f;
    if (bus.exe_run === 1'b1) begin
      bus.exe_done = (d >= 0 && run_idx == d);
      bus.exe_rsp  = exe_fn(bus.exe_cmd);
    end else begin
      bus.exe_done = idle_pulse;
      bus.exe_rsp  = $urandom;
    end
  endtask

  task automatic sample();
    if (bus.exe_run === 1'b1) begin
      if (run_idx == 0) ecmd_log.push_back(bus.exe_cmd);
      run_idx++;
    end else if (run_idx > 0) begin
      run_log.push_back(run_idx);
      run_idx = 0;
    end
    s_rd0 = bus.cmd_rdreq0;
    s_rd1 = bus.cmd_rdreq1;
    if (s_rd0 && s_rd1) viol++;
    if (bus.rsp_wrreq0 && bus.rsp_wrreq1) viol++;
    if (bus.rsp_wrreq0 && bus.rsp_data1 != 0) viol++;
    if (bus.rsp_wrreq1 && bus.rsp_data0 != 0) viol++;
    if (s_rd0 || s_rd1) begin
      tx_idx++;
      g_log.push_back(s_rd1 ? 1 : 0);
      g_cyc.push_back(cyc);
    end
    if (bus.rsp_wrreq0 || bus.rsp_wrreq1) begin
      p_port.push_back(bus.rsp_wrreq1 ? 1 : 0);
      p_dat.push_back(bus.rsp_wrreq1 ? bus.rsp_data1 : bus.rsp_data0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (s_rd0 && cq0.size() != 0) void'(cq0.pop_front());
    if (s_rd1 && cq1.size() != 0) void'(cq1.pop_front());
    cyc++;
    #1;
    drive();
    sample();
  endtask

  // Model: serve preloaded queues by the round-robin rule, one transaction at a time.
  task automatic run_scn(input string tag);
    word_t m0[$], m1[$], e_cmd[$], e_pd[$];
    int    e_port[$], e_run[$], e_pp[$];
    int    last, p, d, i, drops, tmos, load_cyc, n;
    word_t c;
    bit    tmo;
    m0 = cq0; m1 = cq1; last = m_last; i = 0; drops = 0; tmos = 0;
    while (m0.size() != 0 || m1.size() != 0) begin
      if (m0.size() != 0 && m1.size() != 0) p = (last == 0) ? 1 : 0;
      else                                  p = (m0.size() != 0) ? 0 : 1;
      if (p == 1) c = m1.pop_front();
      else        c = m0.pop_front();
      d = 2;
      if (i < dly_tbl.size()) d = dly_tbl[i];
      tmo = (d < 0) || (d >= TCYC);
      e_port.push_back(p);
      e_cmd.push_back(c);
      e_run.push_back(tmo ? TCYC : d + 1);
      if (tmo) tmos++;
      if (i < full_tbl.size() && full_tbl[i]) drops++;
      else begin
        e_pp.push_back(p);
        e_pd.push_back(tmo ? 32'hDEAD_0000 : exe_fn(c));
      end
      last = p;
      i++;
    end
    m_last = last; m_drop += drops; m_tmo += tmos;

    load_cyc = cyc;
    drive();
    n = 0;
    while ((cq0.size() != 0 || cq1.size() != 0 || busy !== 1'b0 || run_idx != 0) && n < 3000) begin
      tick();
      n++;
    end
    check({tag, ".budget"}, 32'(n >= 3000), 0);
    check({tag, ".n_grant"}, g_log.size(), e_port.size());
    check({tag, ".n_push"}, p_port.size(), e_pp.size());
    check({tag, ".n_run"}, run_log.size(), e_run.size());
    for (int k = 0; k < g_log.size() && k < e_port.size(); k++) begin
      check($sformatf("%s.grant%0d", tag, k), g_log[k], e_port[k]);
      if (k < ecmd_log.size()) check($sformatf("%s.exe_cmd%0d", tag, k), ecmd_log[k], e_cmd[k]);
      if (k < run_log.size())  check($sformatf("%s.run_len%0d", tag, k), run_log[k], e_run[k]);
      if (k > 0) check($sformatf("%s.gap%0d", tag, k), g_cyc[k] - g_cyc[k-1], e_run[k-1] + 3);
    end
    if (g_cyc.size() != 0) begin
      check({tag, ".pop_latency"}, g_cyc[0] - load_cyc, 1);
      check({tag, ".gnt_id"}, 32'(gnt_id), m_last);
    end
    for (int k = 0; k < p_port.size() && k < e_pp.size(); k++) begin
      check($sformatf("%s.push_port%0d", tag, k), p_port[k], e_pp[k]);
      check($sformatf("%s.push_dat%0d", tag, k), p_dat[k], e_pd[k]);
    end
    check({tag, ".drop_cnt"}, 32'(drop_cnt), sat(m_drop));
    check({tag, ".tmo_cnt"}, 32'(tmo_cnt), sat(m_tmo));
    check({tag, ".strobe_rules"}, viol, 0);
  endtask

  initial begin
    int n, d;
    tx_idx = -1; cyc = 0; run_idx = 0; viol = 0;
    s_rd0 = 1'b0; s_rd1 = 1'b0; idle_pulse = 1'b0;
    m_last = 1; m_drop = 0; m_tmo = 0;
    drive();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 0);
    check("rst.gnt_id", 32'(gnt_id), 0);
    check("rst.drop_cnt", 32'(drop_cnt), 0);
    check("rst.tmo_cnt", 32'(tmo_cnt), 0);
    check("rst.strobes", 32'({bus.cmd_rdreq0, bus.cmd_rdreq1, bus.rsp_wrreq0, bus.rsp_wrreq1, bus.exe_run}), 0);
    check("rst.exe_cmd", bus.exe_cmd, 0);
    rst_n = 1'b1;
    tick();

    // Fairness from reset: three commands on each side.
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      cq0.push_back($urandom);
      cq1.push_back($urandom);
    end
    for (int k = 0; k < 6; k++) add_tx($urandom_range(0, 4), 1'b0);
    run_scn("fair");

    clear_logs();
    cq0.push_back(32'h0000_1234);
    add_tx(3, 1'b0);
    run_scn("req0_only");

    clear_logs();
    cq1.push_back($urandom);
    add_tx(-1, 1'b0);
    run_scn("timeout");

    clear_logs();
    cq1.push_back($urandom);
    add_tx(2, 1'b1);
    run_scn("drop1");

    // Done on the expiry cycle, done one cycle too late, done on first cycle.
    clear_logs();
    for (int k = 0; k < 3; k++) cq0.push_back($urandom);
    add_tx(TCYC - 1, 1'b0);
    add_tx(TCYC, 1'b0);
    add_tx(0, 1'b0);
    run_scn("edges");

    idle_pulse = 1'b1;
    drive();
    tick();
    idle_pulse = 1'b0;
    check("idle_done.busy", 32'(busy), 0);
    tick();
    check("idle_done.busy2", 32'(busy), 0);
    check("idle_done.drop", 32'(drop_cnt), sat(m_drop));
    check("idle_done.tmo", 32'(tmo_cnt), sat(m_tmo));

    clear_logs();
    for (int k = 0; k < 3; k++) cq0.push_back($urandom);
    for (int k = 0; k < 2; k++) cq1.push_back($urandom);
    for (int k = 0; k < 5; k++) add_tx((k < 3) ? -1 : 1, 1'b1);
    run_scn("saturate");

    for (int r = 0; r < 8; r++) begin
      clear_logs();
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) cq0.push_back($urandom);
      n = $urandom_range(0, 4);
      for (int k = 0; k < n; k++) cq1.push_back($urandom);
      for (int k = 0; k < 8; k++) begin
        d = int'($urandom_range(0, TCYC + 2)) - 1;
        add_tx(d, $urandom_range(0, 3) == 0);
      end
      run_scn($sformatf("rand%0d", r));
    end

    // Reset while executing: the popped command is abandoned, the next one runs.
    clear_logs();
    cq0.push_back(32'hAAAA_0001);
    cq0.push_back(32'hBBBB_0002);
    add_tx(-1, 1'b0);
    drive();
    n = 0;
    while (bus.exe_run !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("mid_rst.pre_run", 32'(bus.exe_run), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst.exe_run", 32'(bus.exe_run), 0);
    check("mid_rst.strobes", 32'({bus.cmd_rdreq0, bus.cmd_rdreq1, bus.rsp_wrreq0, bus.rsp_wrreq1}), 0);
    check("mid_rst.busy", 32'(busy), 0);
    check("mid_rst.gnt_id", 32'(gnt_id), 0);
    check("mid_rst.counters", 32'({drop_cnt, tmo_cnt}), 0);
    m_last = 1; m_drop = 0; m_tmo = 0;
    run_idx = 0; s_rd0 = 1'b0; s_rd1 = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    clear_logs();
    add_tx(2, 1'b0);
    run_scn("post_rst");
    check("post_rst.cmd", (ecmd_log.size() != 0) ? ecmd_log[0] : 32'h0, 32'hBBBB_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
